sid_voice_sched: RTL and testbench
==================================

Name: sid_voice_sched

Overview:
- Time-multiplexes one shared sid_voice instance (waveform selector, DAC and voice DCA pipeline) across all 3 voices of NSIDS SID cores.
- On each SID-cycle tick it snapshots every voice's waveform and envelope inputs, then issues them to the shared sid_voice one slot per clk.
- It realigns the returned results using the pipeline latency and publishes a complete, atomically updated frame of voice outputs plus OSC3 values.
- Sits between the per-SID oscillator/envelope blocks and the filter/mixer.

Parameters:
- NSIDS, 2, number of SID cores sharing the pipeline (1..4).
- VOICE_LAT, 1, clk cycles from dca_voice_o to valid dca_res_i (latency of sid_voice).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick_i  in  1  one-cycle strobe: start of a SID cycle.
- model_i  in  NSIDS x sid::model_e  chip model per SID.
- voice_i  in  NSIDS x 3 x sid::voice_i_t  per-voice waveform/envelope inputs.
- dca_model_o  out  sid::model_e  model for the shared sid_voice.
- dca_voice_o  out  sid::voice_i_t  voice inputs for the shared sid_voice.
- dca_res_i  in  sid::s24_t  voice_o returned by sid_voice.
- dca_osc_i  in  sid::reg8_t  osc_o returned by sid_voice.
- voice_o  out  NSIDS x 3 x sid::s24_t  published voice results.
- osc3_o  out  NSIDS x sid::reg8_t  published OSC3 (voice 2 osc) per SID.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle strobe: new frame published.
- overrun_o  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset: all outputs 0, including dca_voice_o (selector 0, envelope 0), dca_model_o = sid::MOS6581 (0) and the snapshot/staging registers; FSM to IDLE. Reset asserted mid-frame aborts the frame; no done_o, voice_o stays 0.
- Slot order k = 0..3*NSIDS-1: sid = k/3, voice = k%3 (S0V0, S0V1, S0V2, S1V0, ...).
- FSM states and transitions:
  - IDLE: tick_i -> ISSUE.
  - ISSUE: after the last slot -> DRAIN.
  - DRAIN: after the last capture -> DONE.
  - DONE: one cycle -> IDLE, or -> ISSUE if tick_i is high in that cycle.
- Timing (tick_i high in cycle 0; clocked events happen at the end of the stated cycle):
  - Cycle 0: all voice_i and model_i snapshotted into the shadow register. Later input changes do not affect the frame.
  - Cycle 1+k: slot k driven on dca_voice_o/dca_model_o from the snapshot.
  - Cycle 1+k+VOICE_LAT: dca_res_i captured into staging[sid][voice]. For voice 2 only, dca_osc_i is also captured into osc staging[sid].
  - Cycle 3*NSIDS+VOICE_LAT+1: staging copied to voice_o/osc3_o (all values change together, at the start of that cycle), and done_o is high.
- busy_o is high in cycles 1..3*NSIDS+VOICE_LAT.
- Result alignment uses a VOICE_LAT-deep delay line of {valid, slot index}, not the FSM state.
- Outside ISSUE, dca_voice_o is driven all-zero and dca_model_o holds the last issued model.
- tick_i while busy_o=1: tick ignored, overrun_o set (cleared only by rst_n).
- tick_i in the DONE cycle: accepted, with snapshot in that cycle; back-to-back frames have no idle gap.
- tick_i during reset: ignored.
- No arithmetic on data: results are passed through unmodified at full width.
- Slot counter width is clog2(3*NSIDS) and wraps to 0 on frame end.

Decomposition:
- Package sid additions:
  - sched_state_e {IDLE, ISSUE, DRAIN, DONE}.
  - Constant VOICES_PER_SID = 3.
  - Typedef slot_t sized for 3*4 slots.
- One sub-module, sid_slot_delay: a parameterised VOICE_LAT-stage shift register of {valid, slot_t}, reset to 0, with VOICE_LAT=0 allowed as a pass-through.
- sid_voice stays instantiated outside this block, at the top level.

Test Plan:
- Basic frame, NSIDS=2, VOICE_LAT=1, bench model of sid_voice returning res = {slot, 16'h00A5}: tick at cycle 0 -> dca_voice_o slots 0..5 in cycles 1..6, busy 1..7, done at cycle 8, voice_o[1][2] = 24'h0500A5.
- Snapshot: change voice_i[0][1].envelope from 8'h40 to 8'hFF in cycle 1 -> slot 1 issued in cycle 2 still carries 8'h40.
- Overrun: second tick at cycle 4 -> ignored, overrun_o=1 from cycle 5 and stays set, done_o still at cycle 8 only.
- Back-to-back: tick at cycle 0 and cycle 8 -> second frame issues slot 0 in cycle 9, done at cycle 16, overrun_o=0.
- Reset mid-frame: rst_n low at cycle 3 -> all outputs 0 immediately, no done_o; next tick gives a normal frame.
- Latency sweep: VOICE_LAT=3, NSIDS=1 -> done at cycle 7; osc3_o[0] equals the dca_osc_i returned for slot 2.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared SID types plus the scheduler additions: FSM states, slot index and
// the {valid, slot} tag carried alongside the shared voice pipeline.
package sid;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  typedef logic [7:0]         reg8_t;
  typedef logic signed [23:0] s24_t;

  typedef struct packed {
    logic [3:0]  selector;
    logic [11:0] acc;
    logic [7:0]  envelope;
  } voice_i_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int VOICES_PER_SID = 3;
  localparam int MAX_SLOTS      = VOICES_PER_SID * 4;

  typedef logic [$clog2(MAX_SLOTS)-1:0] slot_t;

  typedef struct packed {
    logic  valid;
    slot_t slot;
  } slot_tag_t;

endpackage

// File: rtl/sid_voice_sched_slot_delay.sv
// VOICE_LAT-stage shift register of {valid, slot}; VOICE_LAT=0 is a wire.
// Lets results be matched to slots independently of the scheduler state.
module sid_slot_delay
  import sid::*;
#(
  parameter int VOICE_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  slot_tag_t tag_i,
  output slot_tag_t tag_o
);

  generate
    if (VOICE_LAT == 0) begin : g_pass
      assign tag_o = tag_i;
    end else begin : g_pipe
      slot_tag_t pipe_q [VOICE_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < VOICE_LAT; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= tag_i;
          for (int i = 1; i < VOICE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign tag_o = pipe_q[VOICE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/sid_voice_sched.sv
// Time-multiplexes one shared sid_voice across 3*NSIDS voices: snapshot on
// tick, issue one slot per clk, realign results, publish a whole frame at once.
module sid_voice_sched
  import sid::*;
#(
  parameter int NSIDS     = 2,
  parameter int VOICE_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick_i,
  input  model_e   model_i [NSIDS],
  input  voice_i_t voice_i [NSIDS][VOICES_PER_SID],
  output model_e   dca_model_o,
  output voice_i_t dca_voice_o,
  input  s24_t     dca_res_i,
  input  reg8_t    dca_osc_i,
  output s24_t     voice_o [NSIDS][VOICES_PER_SID],
  output reg8_t    osc3_o [NSIDS],
  output logic     busy_o,
  output logic     done_o,
  output logic     overrun_o
);

  localparam int              NSLOTS    = VOICES_PER_SID * NSIDS;
  localparam int              SW        = $clog2(NSLOTS);
  localparam logic [SW-1:0]   LAST_SLOT = SW'(NSLOTS - 1);
  localparam slot_t           LAST_TAG  = slot_t'(NSLOTS - 1);

  sched_state_e  state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  model_e        snap_model_q [NSIDS], snap_model_d [NSIDS];
  voice_i_t      snap_voice_q [NSIDS][VOICES_PER_SID], snap_voice_d [NSIDS][VOICES_PER_SID];
  s24_t          stage_q [NSIDS][VOICES_PER_SID], stage_d [NSIDS][VOICES_PER_SID];
  reg8_t         ostage_q [NSIDS], ostage_d [NSIDS];
  s24_t          voice_q [NSIDS][VOICES_PER_SID], voice_d [NSIDS][VOICES_PER_SID];
  reg8_t         osc3_q [NSIDS], osc3_d [NSIDS];
  model_e        last_model_q, last_model_d;
  logic          busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

  model_e        dca_model_c;
  voice_i_t      dca_voice_c;
  slot_tag_t     tag_in, tag_out;
  logic          accept, cap_last;

  sid_slot_delay #(.VOICE_LAT(VOICE_LAT)) u_slot_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    snap_model_d = snap_model_q;
    snap_voice_d = snap_voice_q;
    stage_d      = stage_q;
    ostage_d     = ostage_q;
    voice_d      = voice_q;
    osc3_d       = osc3_q;
    overrun_d    = overrun_q;
    done_d       = 1'b0;

    accept       = tick_i && (state_q == IDLE || state_q == DONE);
    tag_in.valid = (state_q == ISSUE);
    tag_in.slot  = slot_t'(slot_q);
    cap_last     = tag_out.valid && (tag_out.slot == LAST_TAG);

    if (tick_i && !accept) overrun_d = 1'b1;

    // Issue mux: drives the shared pipeline only while a slot is live.
    dca_voice_c = '0;
    dca_model_c = last_model_q;
    for (int s = 0; s < NSIDS; s++) begin
      for (int v = 0; v < VOICES_PER_SID; v++) begin
        if (state_q == ISSUE && slot_q == SW'(s * VOICES_PER_SID + v)) begin
          dca_voice_c = snap_voice_q[s][v];
          dca_model_c = snap_model_q[s];
        end
        if (tag_out.valid && tag_out.slot == slot_t'(s * VOICES_PER_SID + v)) begin
          stage_d[s][v] = dca_res_i;
          if (v == VOICES_PER_SID - 1) ostage_d[s] = dca_osc_i;
        end
      end
    end
    last_model_d = dca_model_c;

    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        if (slot_q == LAST_SLOT) begin
          slot_d  = '0;
          state_d = cap_last ? DONE : DRAIN;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      DRAIN: if (cap_last) state_d = DONE;
      DONE:  state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    // The final capture is merged in here so the frame publishes in one edge.
    if (cap_last) begin
      voice_d = stage_d;
      osc3_d  = ostage_d;
      done_d  = 1'b1;
    end

    if (accept) begin
      snap_model_d = model_i;
      snap_voice_d = voice_i;
    end

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      last_model_q <= MOS6581;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int s = 0; s < NSIDS; s++) begin
        snap_model_q[s] <= MOS6581;
        ostage_q[s]     <= '0;
        osc3_q[s]       <= '0;
        for (int v = 0; v < VOICES_PER_SID; v++) begin
          snap_voice_q[s][v] <= '0;
          stage_q[s][v]      <= '0;
          voice_q[s][v]      <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      last_model_q <= last_model_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      snap_model_q <= snap_model_d;
      snap_voice_q <= snap_voice_d;
      stage_q      <= stage_d;
      ostage_q     <= ostage_d;
      voice_q      <= voice_d;
      osc3_q       <= osc3_d;
    end
  end

  assign dca_voice_o = dca_voice_c;
  assign dca_model_o = dca_model_c;
  assign voice_o     = voice_q;
  assign osc3_o      = osc3_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sid_voice_sched.sv
// Directed bench: two scheduler configurations, each fed by a small behavioural
// model of sid_voice returning res = {acc[7:0], 16'h00A5}, osc = {4'hC, acc[3:0]}.
module tb_sid_voice_sched;
  import sid::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Configuration A: NSIDS=2, VOICE_LAT=1
  logic     tick_a = 1'b0;
  model_e   model_a [2];
  voice_i_t vin_a [2][3];
  model_e   dca_model_a;
  voice_i_t dca_voice_a;
  s24_t     res_a = '0;
  reg8_t    osc_a = '0;
  s24_t     vout_a [2][3];
  reg8_t    osc3_a [2];
  logic     busy_a, done_a, overrun_a;

  sid_voice_sched #(.NSIDS(2), .VOICE_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_a), .model_i(model_a), .voice_i(vin_a),
    .dca_model_o(dca_model_a), .dca_voice_o(dca_voice_a), .dca_res_i(res_a),
    .dca_osc_i(osc_a), .voice_o(vout_a), .osc3_o(osc3_a), .busy_o(busy_a),
    .done_o(done_a), .overrun_o(overrun_a)
  );

  always @(posedge clk) begin
    res_a <= {dca_voice_a.acc[7:0], 16'h00A5};
    osc_a <= {4'hC, dca_voice_a.acc[3:0]};
  end

  // Configuration B: NSIDS=1, VOICE_LAT=3
  logic     tick_b = 1'b0;
  model_e   model_b [1];
  voice_i_t vin_b [1][3];
  model_e   dca_model_b;
  voice_i_t dca_voice_b;
  s24_t     res_b_p [3];
  reg8_t    osc_b_p [3];
  s24_t     vout_b [1][3];
  reg8_t    osc3_b [1];
  logic     busy_b, done_b, overrun_b;

  sid_voice_sched #(.NSIDS(1), .VOICE_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_b), .model_i(model_b), .voice_i(vin_b),
    .dca_model_o(dca_model_b), .dca_voice_o(dca_voice_b), .dca_res_i(res_b_p[2]),
    .dca_osc_i(osc_b_p[2]), .voice_o(vout_b), .osc3_o(osc3_b), .busy_o(busy_b),
    .done_o(done_b), .overrun_o(overrun_b)
  );

  always @(posedge clk) begin
    res_b_p[0] <= {dca_voice_b.acc[7:0], 16'h00A5};
    osc_b_p[0] <= {4'hC, dca_voice_b.acc[3:0]};
    res_b_p[1] <= res_b_p[0];
    osc_b_p[1] <= osc_b_p[0];
    res_b_p[2] <= res_b_p[1];
    osc_b_p[2] <= osc_b_p[1];
  end

  task automatic init_stimulus();
    model_a[0] = MOS6581;
    model_a[1] = MOS8580;
    model_b[0] = MOS8580;
    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 3; v++)
        vin_a[s][v] = '{selector: 4'h8, acc: 12'(3 * s + v), envelope: 8'h40};
    for (int v = 0; v < 3; v++)
      vin_b[0][v] = '{selector: 4'h4, acc: 12'(v), envelope: 8'h20};
    for (int i = 0; i < 3; i++) begin
      res_b_p[i] = '0;
      osc_b_p[i] = '0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    tick_a = 1'b1;
    tick_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a got %b exp 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done_a got %b exp 0", done_a); end
    n_cmp++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_a got %b exp 0", overrun_a); end
    n_cmp++; if (dca_voice_a !== '0) begin n_fail++; $display("FAIL reset_dca_voice got %h exp 0", dca_voice_a); end
    n_cmp++; if (dca_model_a !== MOS6581) begin n_fail++; $display("FAIL reset_dca_model got %0d exp 0", dca_model_a); end
    n_cmp++; if (vout_a[1][2] !== 24'h0) begin n_fail++; $display("FAIL reset_voice_o got %h exp 0", vout_a[1][2]); end
    n_cmp++; if (osc3_a[1] !== 8'h0) begin n_fail++; $display("FAIL reset_osc3 got %h exp 0", osc3_a[1]); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got %b exp 0", busy_b); end
    tick_a = 1'b0;
    tick_b = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_tick_ignored got %b exp 0", busy_a); end
  endtask

  task automatic test_basic();
    logic     exp_busy, exp_done;
    voice_i_t exp_v;
    model_e   exp_m;
    s24_t     exp_r;
    for (int c = 0; c < 10; c++) begin
      tick_a   = (c == 0);
      exp_busy = (c >= 1 && c <= 7);
      exp_done = (c == 8);
      exp_v    = '0;
      if (c >= 1 && c <= 6) exp_v = vin_a[(c - 1) / 3][(c - 1) % 3];
      exp_m    = (c >= 4) ? MOS8580 : MOS6581;
      n_cmp++; if (busy_a !== exp_busy) begin n_fail++; $display("FAIL basic_busy c=%0d got %b exp %b", c, busy_a, exp_busy); end
      n_cmp++; if (done_a !== exp_done) begin n_fail++; $display("FAIL basic_done c=%0d got %b exp %b", c, done_a, exp_done); end
      n_cmp++; if (dca_voice_a !== exp_v) begin n_fail++; $display("FAIL basic_dca_voice c=%0d got %h exp %h", c, dca_voice_a, exp_v); end
      n_cmp++; if (dca_model_a !== exp_m) begin n_fail++; $display("FAIL basic_dca_model c=%0d got %0d exp %0d", c, dca_model_a, exp_m); end
      if (c < 8) begin
        n_cmp++; if (vout_a[1][2] !== 24'h0) begin n_fail++; $display("FAIL basic_early_publish c=%0d got %h exp 0", c, vout_a[1][2]); end
      end
      if (c == 8) begin
        for (int s = 0; s < 2; s++) begin
          for (int v = 0; v < 3; v++) begin
            exp_r = {8'(3 * s + v), 16'h00A5};
            n_cmp++; if (vout_a[s][v] !== exp_r) begin n_fail++; $display("FAIL basic_voice_o[%0d][%0d] got %h exp %h", s, v, vout_a[s][v], exp_r); end
          end
        end
        n_cmp++; if (osc3_a[0] !== 8'hC2) begin n_fail++; $display("FAIL basic_osc3[0] got %h exp c2", osc3_a[0]); end
        n_cmp++; if (osc3_a[1] !== 8'hC5) begin n_fail++; $display("FAIL basic_osc3[1] got %h exp c5", osc3_a[1]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_snapshot();
    for (int c = 0; c < 10; c++) begin
      tick_a = (c == 0);
      if (c == 1) begin
        vin_a[0][1].envelope = 8'hFF;
        vin_a[1][2].acc      = 12'h0FF;
      end
      if (c == 2) begin
        n_cmp++; if (dca_voice_a.envelope !== 8'h40) begin n_fail++; $display("FAIL snap_envelope got %h exp 40", dca_voice_a.envelope); end
      end
      if (c == 6) begin
        n_cmp++; if (dca_voice_a.acc !== 12'h005) begin n_fail++; $display("FAIL snap_acc got %h exp 005", dca_voice_a.acc); end
      end
      if (c == 8) begin
        n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL snap_done got %b exp 1", done_a); end
        n_cmp++; if (vout_a[1][2] !== 24'h0500A5) begin n_fail++; $display("FAIL snap_voice_o got %h exp 0500a5", vout_a[1][2]); end
      end
      @(posedge clk); #1;
    end
    vin_a[0][1].envelope = 8'h40;
    vin_a[1][2].acc      = 12'h005;
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    for (int c = 0; c < 18; c++) begin
      tick_a   = (c == 0 || c == 8);
      exp_busy = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
      exp_done = (c == 8 || c == 16);
      n_cmp++; if (busy_a !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy_a, exp_busy); end
      n_cmp++; if (done_a !== exp_done) begin n_fail++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done_a, exp_done); end
      if (c == 9) begin
        n_cmp++; if (dca_voice_a !== vin_a[0][0]) begin n_fail++; $display("FAIL b2b_slot0 got %h exp %h", dca_voice_a, vin_a[0][0]); end
      end
      if (c == 16) begin
        n_cmp++; if (vout_a[0][0] !== 24'h0000A5) begin n_fail++; $display("FAIL b2b_voice_o got %h exp 0000a5", vout_a[0][0]); end
      end
      @(posedge clk); #1;
    end
    tick_a = 1'b0;
    n_cmp++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", overrun_a); end
  endtask

  task automatic test_overrun();
    logic exp_ovr, exp_done;
    for (int c = 0; c < 12; c++) begin
      tick_a   = (c == 0 || c == 4);
      exp_ovr  = (c >= 5);
      exp_done = (c == 8);
      n_cmp++; if (overrun_a !== exp_ovr) begin n_fail++; $display("FAIL ovr_flag c=%0d got %b exp %b", c, overrun_a, exp_ovr); end
      n_cmp++; if (done_a !== exp_done) begin n_fail++; $display("FAIL ovr_done c=%0d got %b exp %b", c, done_a, exp_done); end
      @(posedge clk); #1;
    end
    tick_a = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    for (int c = 0; c < 13; c++) begin
      tick_a = (c == 0 || c == 4);
      if (c == 3) begin
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy_a); end
        n_cmp++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun got %b exp 0", overrun_a); end
        n_cmp++; if (dca_voice_a !== '0) begin n_fail++; $display("FAIL rstmid_dca_voice got %h exp 0", dca_voice_a); end
        n_cmp++; if (vout_a[1][2] !== 24'h0) begin n_fail++; $display("FAIL rstmid_voice_o got %h exp 0", vout_a[1][2]); end
        n_cmp++; if (osc3_a[0] !== 8'h0) begin n_fail++; $display("FAIL rstmid_osc3 got %h exp 0", osc3_a[0]); end
      end
      if (c == 5) rst_n = 1'b1;
      if (c >= 6) begin
        n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle c=%0d got %b exp 0", c, busy_a); end
      end
      n_cmp++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done c=%0d got %b exp 0", c, done_a); end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 10; c++) begin
      tick_a = (c == 0);
      if (c == 8) begin
        n_cmp++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_done got %b exp 1", done_a); end
        n_cmp++; if (vout_a[1][2] !== 24'h0500A5) begin n_fail++; $display("FAIL rstmid_next_voice got %h exp 0500a5", vout_a[1][2]); end
      end
      @(posedge clk); #1;
    end
    tick_a = 1'b0;
  endtask

  task automatic test_latency_sweep();
    logic     exp_busy, exp_done;
    voice_i_t exp_v;
    s24_t     exp_r;
    for (int c = 0; c < 10; c++) begin
      tick_b   = (c == 0);
      exp_busy = (c >= 1 && c <= 6);
      exp_done = (c == 7);
      exp_v    = '0;
      if (c >= 1 && c <= 3) exp_v = vin_b[0][c - 1];
      n_cmp++; if (busy_b !== exp_busy) begin n_fail++; $display("FAIL lat_busy c=%0d got %b exp %b", c, busy_b, exp_busy); end
      n_cmp++; if (done_b !== exp_done) begin n_fail++; $display("FAIL lat_done c=%0d got %b exp %b", c, done_b, exp_done); end
      n_cmp++; if (dca_voice_b !== exp_v) begin n_fail++; $display("FAIL lat_dca_voice c=%0d got %h exp %h", c, dca_voice_b, exp_v); end
      if (c == 7) begin
        for (int v = 0; v < 3; v++) begin
          exp_r = {8'(v), 16'h00A5};
          n_cmp++; if (vout_b[0][v] !== exp_r) begin n_fail++; $display("FAIL lat_voice_o[%0d] got %h exp %h", v, vout_b[0][v], exp_r); end
        end
        n_cmp++; if (osc3_b[0] !== 8'hC2) begin n_fail++; $display("FAIL lat_osc3 got %h exp c2", osc3_b[0]); end
        n_cmp++; if (dca_model_b !== MOS8580) begin n_fail++; $display("FAIL lat_model_hold got %0d exp 1", dca_model_b); end
      end
      @(posedge clk); #1;
    end
    tick_b = 1'b0;
  endtask

  initial begin
    init_stimulus();
    test_reset();
    test_basic();
    test_snapshot();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_latency_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
